// File: rtl/key_pulse_generator_if.sv
// Key pulse generator bundle: raw active-low keys in,
// debounced pulses and held levels out.
interface key_pulse_generator_if;
    logic key_start_n;
    logic key_select_n;
    logic flip_working;
    logic shift_selection;
    logic start_held;
    logic select_held;

    modport master (
        output key_start_n,
        output key_select_n,
        input  flip_working,
        input  shift_selection,
        input  start_held,
        input  select_held
    );

    modport slave (
        input  key_start_n,
        input  key_select_n,
        output flip_working,
        output shift_selection,
        output start_held,
        output select_held
    );
endinterface

// File: rtl/key_pulse_generator.sv
// Start/select key debouncer: per-key 2-flop sync, FSM and pulse output.
// Select-key auto-repeat is built only with `KEY_AUTO_REPEAT_EN defined.
module key_pulse_generator #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    key_pulse_generator_if.slave kp
);
    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                            DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ?
                            MAX_AB : REPEAT_PERIOD;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
`endif

    logic [1:0] raw_n;
    logic [1:0] pulse;
    logic [1:0] held;

    assign raw_n = {kp.key_select_n, kp.key_start_n};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic          meta_q, meta_d;
        logic          sync_q, sync_d;
        logic          s;
        state_e        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          pulse_q, pulse_d;
`ifdef KEY_AUTO_REPEAT_EN
        // rep_q: next repeat uses the initial delay, not the period
        localparam bit REP = (k == 1);
        logic          rep_q, rep_d;
`endif

        assign s = ~sync_q;

        always_comb begin
            meta_d  = raw_n[k];
            sync_d  = meta_q;
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
            rep_d   = rep_q;
`endif
            unique case (state_q)
                RELEASED: begin
                    if (s) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_d = RELEASED;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
                        rep_d   = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
`ifdef KEY_AUTO_REPEAT_EN
                    end else if (REP) begin
                        if (cnt_q == (rep_q ? DLY_LAST : PER_LAST)) begin
                            cnt_d   = '0;
                            pulse_d = 1'b1;
                            rep_d   = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_d = HELD;
                        cnt_d   = '0;
`ifdef KEY_AUTO_REPEAT_EN
                        rep_d   = 1'b1;
`endif
                    end else if (cnt_q == DB_LAST) begin
                        state_d = RELEASED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = RELEASED;
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                meta_q  <= 1'b1;
                sync_q  <= 1'b1;
                state_q <= RELEASED;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
                rep_q   <= 1'b0;
`endif
            end else begin
                meta_q  <= meta_d;
                sync_q  <= sync_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
`ifdef KEY_AUTO_REPEAT_EN
                rep_q   <= rep_d;
`endif
            end
        end

        assign pulse[k] = pulse_q;
        assign held[k]  = (state_q == HELD) ||
                          (state_q == RELEASE_WAIT);
    end

    assign kp.flip_working    = pulse[0];
    assign kp.shift_selection = pulse[1];
    assign kp.start_held      = held[0];
    assign kp.select_held     = held[1];
endmodule

// File: tb/tb_key_pulse_generator.sv
// Bench for key_pulse_generator: run-length debounce model checked every
// cycle, plus directed scenarios with hand-computed pulse timing.
module tb_key_pulse_generator;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   chk_en   = 1'b0;

    key_pulse_generator_if kif ();

    key_pulse_generator #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .kp     (kif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: level flips after D+1 consecutive disagreeing synced samples
    logic [1:0] m_raw1  = 2'b11;
    logic [1:0] m_raw2  = 2'b11;
    logic [1:0] m_lvl   = 2'b00;
    logic [1:0] m_pulse = 2'b00;
    int         m_run[2] = '{0, 0};
    int         m_t[2]   = '{0, 0};

    always @(posedge clk or negedge reset_n) begin : model
        bit s, l, p;
        int r, tt;
        if (!reset_n) begin
            m_raw1  <= 2'b11;
            m_raw2  <= 2'b11;
            m_lvl   <= 2'b00;
            m_pulse <= 2'b00;
            m_run   <= '{0, 0};
            m_t     <= '{0, 0};
        end else begin
            m_raw1 <= {kif.key_select_n, kif.key_start_n};
            m_raw2 <= m_raw1;
            for (int k = 0; k < 2; k++) begin
                s  = !m_raw2[k];
                l  = m_lvl[k];
                r  = m_run[k];
                tt = m_t[k];
                p  = 1'b0;
                if (s == l) begin
                    if (l && r > 0) begin
                        tt = 0;
                    end else if (l) begin
                        tt = tt + 1;
                        if (REP && k == 1 && tt >= RD &&
                            (tt - RD) % RP == 0)
                            p = 1'b1;
                    end
                    r = 0;
                end else begin
                    r = r + 1;
                    if (r == D + 1) begin
                        l = s;
                        r = 0;
                        if (s) begin
                            p  = 1'b1;
                            tt = 0;
                        end
                    end
                end
                m_lvl[k]   <= l;
                m_pulse[k] <= p;
                m_run[k]   <= r;
                m_t[k]     <= tt;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d",
                     name, cyc, got, exp);
        end
    endtask

    int fw_q[$];
    int sw_q[$];
    int sh_fall  = -1;
    bit prev_sh  = 1'b0;
    bit sel_seen = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_flip_working", int'(kif.flip_working),
                int'(m_pulse[0]));
            chk("cyc_shift_selection", int'(kif.shift_selection),
                int'(m_pulse[1]));
            chk("cyc_start_held", int'(kif.start_held), int'(m_lvl[0]));
            chk("cyc_select_held", int'(kif.select_held), int'(m_lvl[1]));
        end
        if (kif.flip_working === 1'b1) fw_q.push_back(cyc);
        if (kif.shift_selection === 1'b1) sw_q.push_back(cyc);
        if (prev_sh && kif.start_held === 1'b0) sh_fall = cyc;
        prev_sh = (kif.start_held === 1'b1);
        if (kif.select_held === 1'b1) sel_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        fw_q.delete();
        sw_q.delete();
        sh_fall  = -1;
        sel_seen = 1'b0;
    endtask

    function automatic int first_of(input int q[$], input int base);
        return (q.size() > 0) ? q[0] - base : -1;
    endfunction

    int t0, t1, tr, n_exp;
    int exp_rep[7] = '{6, 16, 19, 22, 25, 28, 31};
    bit bounce_on[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        kif.key_start_n  = 1'b1;
        kif.key_select_n = 1'b1;
        tick(3);
        chk_en = 1'b1;
        chk("rst_flip", int'(kif.flip_working), 0);
        chk("rst_shift", int'(kif.shift_selection), 0);
        chk("rst_start_held", int'(kif.start_held), 0);
        chk("rst_select_held", int'(kif.select_held), 0);
        reset_n = 1'b1;
        tick(3);

        // clean start press, 20 cycles
        clear_log();
        t0 = cyc + 1;
        kif.key_start_n = 1'b0;
        tick(20);
        t1 = cyc + 1;
        kif.key_start_n = 1'b1;
        tick(12);
        chk("start_pulse_count", fw_q.size(), 1);
        chk("start_pulse_latency", first_of(fw_q, t0), 6);
        chk("start_held_fall", sh_fall - t1, 6);
        chk("start_no_select", sw_q.size(), 0);

        // 3-cycle glitch on select
        clear_log();
        kif.key_select_n = 1'b0;
        tick(3);
        kif.key_select_n = 1'b1;
        tick(10);
        chk("glitch_no_pulse", sw_q.size(), 0);
        chk("glitch_no_held", int'(sel_seen), 0);

        // bouncing press and release on select
        clear_log();
        t0 = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            kif.key_select_n = bounce_on[i];
            tick(1);
        end
        kif.key_select_n = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            kif.key_select_n = ~bounce_on[i];
            tick(1);
        end
        kif.key_select_n = 1'b1;
        tick(12);
        chk("bounce_pulse_count", sw_q.size(), 1);
        chk("bounce_pulse_latency", first_of(sw_q, t0), 10);

        // both keys on the same edge
        clear_log();
        t0 = cyc + 1;
        kif.key_start_n  = 1'b0;
        kif.key_select_n = 1'b0;
        tick(8);
        kif.key_start_n  = 1'b1;
        kif.key_select_n = 1'b1;
        tick(12);
        chk("both_flip_count", fw_q.size(), 1);
        chk("both_shift_count", sw_q.size(), 1);
        chk("both_flip_latency", first_of(fw_q, t0), 6);
        chk("both_shift_latency", first_of(sw_q, t0), 6);

        // select held 30 cycles: auto-repeat when enabled
        clear_log();
        t0 = cyc + 1;
        kif.key_select_n = 1'b0;
        tick(30);
        kif.key_select_n = 1'b1;
        tick(12);
        n_exp = REP ? 7 : 1;
        chk("hold_pulse_count", sw_q.size(), n_exp);
        for (int i = 0; i < n_exp; i++)
            chk("hold_pulse_time",
                (i < sw_q.size()) ? sw_q[i] - t0 : -1, exp_rep[i]);
        chk("hold_no_flip", fw_q.size(), 0);

        // reset during PRESS_WAIT, key kept pressed
        clear_log();
        kif.key_select_n = 1'b0;
        tick(4);
        #2 reset_n = 1'b0;
        tick(1);
        chk("midrst_shift", int'(kif.shift_selection), 0);
        chk("midrst_select_held", int'(kif.select_held), 0);
        tick(2);
        chk("midrst_no_pulse", sw_q.size(), 0);
        reset_n = 1'b1;
        tr = cyc + 1;
        tick(10);
        chk("midrst_pulse_count", sw_q.size(), 1);
        chk("midrst_pulse_latency", first_of(sw_q, tr), 6);
        kif.key_select_n = 1'b1;
        tick(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
